keypad_scan: RTL and testbench
==============================

KEYPAD_SCAN -- requirements
Module: keypad_scan

Interface
REQ-001 Parameter SCAN_DIV, default 1000: IN_clk cycles per scan tick; legal range 2..65535.
REQ-002 Parameter DEBOUNCE_CNT, default 20: consecutive identical tick samples needed for press/release; legal range 2..255.
REQ-003 Parameter REPEAT_DLY, default 500: ticks held before first auto-repeat; used only with KEYPAD_REPEAT_EN.
REQ-004 Parameter REPEAT_PER, default 100: ticks between subsequent auto-repeats; used only with KEYPAD_REPEAT_EN.
REQ-005 IN_clk  input  1  system clock; all state changes on rising edge.
REQ-006 IN_reset  input  1  asynchronous, active-low reset.
REQ-007 IN_row  input  4  matrix row returns, active-low, externally pulled up, asynchronous to IN_clk.
REQ-008 OUT_col  output  4  column drive, active-low, exactly one bit low at all times.
REQ-009 OUT_value  output  4  code of last accepted key, {row[1:0], col[1:0]}; held until next accepted key.
REQ-010 OUT_key  output  1  one-IN_clk-cycle strobe per accepted key event; OUT_value valid in the same cycle.
REQ-011 OUT_held  output  1  high while a debounced key is held (state PRESSED).

Function
REQ-012 IN_row SHALL pass through a two-flop synchronizer; all decisions use synchronized rows.
REQ-013 Tick divider SHALL count 0..SCAN_DIV-1 and assert an internal tick for one cycle at terminal count, then wrap to 0.
REQ-014 States SHALL be SCAN, DEBOUNCE, PRESSED; all transitions and samples occur only on tick cycles.
REQ-015 SCAN: if any row low, capture lowest-index low row and current column, sample count=1, go DEBOUNCE, hold column; else advance column 0->1->2->3->0 (OUT_col 1110,1101,1011,0111).
REQ-016 DEBOUNCE: same captured row low (lower-index rows high) SHALL increment count; any other sample SHALL clear count, advance column, return to SCAN.
REQ-017 When count reaches DEBOUNCE_CNT: OUT_value updated, OUT_key high in the following cycle only, count cleared, go PRESSED.
REQ-018 PRESSED: column held; captured row high increments release count, low clears it; release count reaching DEBOUNCE_CNT SHALL advance column and go SCAN.
REQ-019 Other keys pressed while in PRESSED SHALL be ignored (no rollover); no further strobe except per REQ-024.
REQ-020 Multiple rows low in one column SHALL resolve to lowest row index; keys in other columns SHALL be invisible until scanned.
REQ-021 OUT_key SHALL never be high on two consecutive cycles.

Reset
REQ-022 IN_reset low SHALL immediately force: state SCAN, OUT_col 4'b1110, OUT_value 4'h0, OUT_key 0, OUT_held 0, divider, debounce, release and repeat counters 0, synchronizer flops 4'hF.
REQ-023 Reset mid-operation SHALL discard partial debounce; a key still held after reset release SHALL be re-detected and produce exactly one strobe after full debounce.

Configuration
REQ-024 With KEYPAD_REPEAT_EN defined: in PRESSED, after REPEAT_DLY ticks without release, OUT_key SHALL pulse again (same OUT_value), then every REPEAT_PER ticks; repeat counter cleared on entry to PRESSED and on any low-to-high release sample.
REQ-025 Without KEYPAD_REPEAT_EN: no repeat counter logic; exactly one strobe per press regardless of hold duration.

Verification (SCAN_DIV=4, DEBOUNCE_CNT=3 unless stated)
REQ-026 No key, 5 ticks -> OUT_col 1110,1101,1011,0111,1110; OUT_key never high.
REQ-027 Row2 held low while column1 driven, 20 ticks -> one OUT_key pulse, OUT_value 4'h9, OUT_held 1 until 3 ticks after release.
REQ-028 Row0 bouncing every tick for 10 ticks on column3, then stable low -> no strobe during bounce, one strobe with OUT_value 4'h3 after 3 stable samples.
REQ-029 Rows0 and 3 both low on column0 -> OUT_value 4'h0, single strobe.
REQ-030 IN_reset pulsed low during DEBOUNCE, key kept held -> outputs at reset values immediately; exactly one strobe after reset release plus full debounce.
REQ-031 KEYPAD_REPEAT_EN, REPEAT_DLY=8, REPEAT_PER=4, key held 20 ticks after acceptance -> strobes at acceptance, +8, +12, +16, +20 ticks; without macro only the first.

Source files
------------

// File: rtl/keypad_scan_if.sv
// Pin bundle between keypad_scan and the keypad matrix / key consumer.
// slave is the scanner side, master is the board/consumer side.
interface keypad_scan_if;
   logic [3:0] IN_row;
   logic [3:0] OUT_col;
   logic [3:0] OUT_value;
   logic       OUT_key;
   logic       OUT_held;

   modport slave  (input IN_row, output OUT_col, output OUT_value, output OUT_key, output OUT_held);
   modport master (output IN_row, input OUT_col, input OUT_value, input OUT_key, input OUT_held);
endinterface

// File: rtl/keypad_scan.sv
// 4x4 keypad matrix scanner: tick-paced column scan, debounce and single-key lockout.
// Auto-repeat while a key is held is built in only when KEYPAD_REPEAT_EN is defined.
module keypad_scan #(
   parameter int unsigned SCAN_DIV     = 1000,
   parameter int unsigned DEBOUNCE_CNT = 20,
   parameter int unsigned REPEAT_DLY   = 500,
   parameter int unsigned REPEAT_PER   = 100
) (
   input  logic         IN_clk,
   input  logic         IN_reset,
   keypad_scan_if.slave kp
);

   localparam int unsigned       DIV_W    = $clog2(SCAN_DIV);
   localparam int unsigned       CNT_W    = $clog2(DEBOUNCE_CNT + 1);
   localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(SCAN_DIV - 1);
   localparam logic [CNT_W-1:0]  CNT_DONE = CNT_W'(DEBOUNCE_CNT);

   typedef enum logic [1:0] {
      ST_SCAN,
      ST_DEBOUNCE,
      ST_PRESSED
   } state_t;

   generate
      if (SCAN_DIV < 2 || SCAN_DIV > 65535) begin : g_bad_scan_div
         $error("keypad_scan: SCAN_DIV must be within 2..65535");
      end
      if (DEBOUNCE_CNT < 2 || DEBOUNCE_CNT > 255) begin : g_bad_debounce
         $error("keypad_scan: DEBOUNCE_CNT must be within 2..255");
      end
      if (REPEAT_DLY < 1 || REPEAT_PER < 1) begin : g_bad_repeat
         $error("keypad_scan: REPEAT_DLY and REPEAT_PER must be at least 1");
      end
   endgenerate

   state_t           state_q, state_d;
   logic [3:0]       row_meta_q, row_sync_q;
   logic [DIV_W-1:0] div_q, div_d;
   logic [1:0]       col_q, col_d;
   logic [1:0]       row_cap_q, row_cap_d;
   logic [CNT_W-1:0] deb_q, deb_d;
   logic [CNT_W-1:0] rel_q, rel_d;
   logic [3:0]       value_q, value_d;
   logic             key_q, key_d;

   logic             tick;
   logic             any_low;
   logic             cap_high;
   logic [1:0]       low_idx;
   logic [CNT_W-1:0] deb_inc, rel_inc;

`ifdef KEYPAD_REPEAT_EN
   localparam int unsigned REP_MAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
   localparam int unsigned REP_W   = $clog2(REP_MAX + 1);

   logic [REP_W-1:0] rep_q, rep_d;
   logic [REP_W-1:0] rep_inc, rep_target;
   logic             rep_first_q, rep_first_d;

   assign rep_inc    = rep_q + 1'b1;
   assign rep_target = rep_first_q ? REP_W'(REPEAT_DLY) : REP_W'(REPEAT_PER);
`endif

   // Lowest-index low row wins when several rows in the driven column are pressed.
   always_comb begin
      low_idx = 2'd3;
      if (!row_sync_q[0]) begin
         low_idx = 2'd0;
      end else if (!row_sync_q[1]) begin
         low_idx = 2'd1;
      end else if (!row_sync_q[2]) begin
         low_idx = 2'd2;
      end
   end

   assign tick     = (div_q == DIV_LAST);
   assign any_low  = (row_sync_q != 4'hF);
   assign cap_high = row_sync_q[row_cap_q];
   assign deb_inc  = deb_q + 1'b1;
   assign rel_inc  = rel_q + 1'b1;

   always_comb begin
      state_d   = state_q;
      col_d     = col_q;
      row_cap_d = row_cap_q;
      deb_d     = deb_q;
      rel_d     = rel_q;
      value_d   = value_q;
      key_d     = 1'b0;
      div_d     = tick ? '0 : div_q + 1'b1;
`ifdef KEYPAD_REPEAT_EN
      rep_d       = rep_q;
      rep_first_d = rep_first_q;
`endif

      if (tick) begin
         unique case (state_q)
            ST_SCAN: begin
               if (any_low) begin
                  row_cap_d = low_idx;
                  deb_d     = CNT_W'(1);
                  state_d   = ST_DEBOUNCE;
               end else begin
                  col_d = col_q + 2'd1;
               end
            end

            ST_DEBOUNCE: begin
               if (any_low && (low_idx == row_cap_q)) begin
                  if (deb_inc == CNT_DONE) begin
                     value_d = {row_cap_q, col_q};
                     key_d   = 1'b1;
                     deb_d   = '0;
                     rel_d   = '0;
                     state_d = ST_PRESSED;
`ifdef KEYPAD_REPEAT_EN
                     rep_d       = '0;
                     rep_first_d = 1'b1;
`endif
                  end else begin
                     deb_d = deb_inc;
                  end
               end else begin
                  deb_d   = '0;
                  col_d   = col_q + 2'd1;
                  state_d = ST_SCAN;
               end
            end

            // Only the captured key is watched here; anything else on the matrix is ignored.
            ST_PRESSED: begin
               if (cap_high) begin
                  if (rel_inc == CNT_DONE) begin
                     rel_d   = '0;
                     col_d   = col_q + 2'd1;
                     state_d = ST_SCAN;
                  end else begin
                     rel_d = rel_inc;
                  end
`ifdef KEYPAD_REPEAT_EN
                  rep_d       = '0;
                  rep_first_d = 1'b1;
`endif
               end else begin
                  rel_d = '0;
`ifdef KEYPAD_REPEAT_EN
                  if (rep_inc == rep_target) begin
                     key_d       = 1'b1;
                     rep_d       = '0;
                     rep_first_d = 1'b0;
                  end else begin
                     rep_d = rep_inc;
                  end
`endif
               end
            end

            default: begin
               state_d = ST_SCAN;
            end
         endcase
      end
   end

   always_ff @(posedge IN_clk or negedge IN_reset) begin
      if (!IN_reset) begin
         row_meta_q <= 4'hF;
         row_sync_q <= 4'hF;
         state_q    <= ST_SCAN;
         div_q      <= '0;
         col_q      <= 2'd0;
         row_cap_q  <= 2'd0;
         deb_q      <= '0;
         rel_q      <= '0;
         value_q    <= 4'h0;
         key_q      <= 1'b0;
      end else begin
         row_meta_q <= kp.IN_row;
         row_sync_q <= row_meta_q;
         state_q    <= state_d;
         div_q      <= div_d;
         col_q      <= col_d;
         row_cap_q  <= row_cap_d;
         deb_q      <= deb_d;
         rel_q      <= rel_d;
         value_q    <= value_d;
         key_q      <= key_d;
      end
   end

`ifdef KEYPAD_REPEAT_EN
   always_ff @(posedge IN_clk or negedge IN_reset) begin
      if (!IN_reset) begin
         rep_q       <= '0;
         rep_first_q <= 1'b1;
      end else begin
         rep_q       <= rep_d;
         rep_first_q <= rep_first_d;
      end
   end
`endif

   assign kp.OUT_col   = ~(4'b0001 << col_q);
   assign kp.OUT_value = value_q;
   assign kp.OUT_key   = key_q;
   assign kp.OUT_held  = (state_q == ST_PRESSED);

endmodule

// File: tb/tb_keypad_scan.sv
// Bench for keypad_scan: a modelled key matrix, directed vector table, hand-written corner
// sequences and random key activity, all checked against a tick-level behavioural model.
`timescale 1ns/1ps
module tb_keypad_scan;
   localparam int SCAN_DIV = 4;
   localparam int DEB      = 3;
   localparam int REP_DLY  = 8;
   localparam int REP_PER  = 4;

   typedef struct {
      logic [15:0] keys;
      int          ticks;
      int          exp_strobes;
      logic [3:0]  exp_col;
      logic [3:0]  exp_value;
      logic        exp_held;
   } vec_t;

   logic        IN_clk   = 1'b0;
   logic        IN_reset = 1'b0;
   logic [15:0] keys     = '0;
   int          n_vec    = 0;
   int          n_err    = 0;

   int m_col, m_row, m_run, m_quiet, m_hold, m_value;
   bit m_locked;

   keypad_scan_if kif();

   keypad_scan #(
      .SCAN_DIV    (SCAN_DIV),
      .DEBOUNCE_CNT(DEB),
      .REPEAT_DLY  (REP_DLY),
      .REPEAT_PER  (REP_PER)
   ) dut (
      .IN_clk  (IN_clk),
      .IN_reset(IN_reset),
      .kp      (kif.slave)
   );

   always #5 IN_clk = ~IN_clk;

   // Physical matrix: a pressed key shorts its row to its column when that column is driven low.
   always_comb begin
      kif.IN_row = 4'hF;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            if (keys[r*4+c] && !kif.OUT_col[c]) kif.IN_row[r] = 1'b0;
         end
      end
   end

   initial begin : watchdog
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic logic [3:0] rows_for(input logic [15:0] k, input int col);
      logic [3:0] r;
      for (int i = 0; i < 4; i++) r[i] = !k[i*4+col];
      return r;
   endfunction

   function automatic logic [3:0] col_pattern(input int col);
      logic [3:0] v;
      v = 4'hF;
      v[col] = 1'b0;
      return v;
   endfunction

   task automatic model_reset();
      m_col = 0; m_row = 0; m_run = 0; m_quiet = 0; m_hold = 0; m_value = 0;
      m_locked = 0;
   endtask

   // One scan tick of the keypad rules: streaks of identical samples, with repeats derived from hold time.
   task automatic model_tick(input logic [3:0] rows, output bit strobe);
      int low;
      low = -1;
      for (int r = 3; r >= 0; r--) if (!rows[r]) low = r;
      strobe = 0;
      if (m_locked) begin
         if (rows[m_row]) begin
            m_hold = 0;
            m_quiet++;
            if (m_quiet == DEB) begin
               m_locked = 0;
               m_quiet  = 0;
               m_col    = (m_col + 1) % 4;
            end
         end else begin
            m_quiet = 0;
            m_hold++;
`ifdef KEYPAD_REPEAT_EN
            if (m_hold >= REP_DLY && ((m_hold - REP_DLY) % REP_PER) == 0) strobe = 1;
`endif
         end
      end else if (m_run == 0) begin
         if (low >= 0) begin
            m_row = low;
            m_run = 1;
         end else begin
            m_col = (m_col + 1) % 4;
         end
      end else if (low == m_row) begin
         m_run++;
         if (m_run == DEB) begin
            strobe   = 1;
            m_value  = m_row * 4 + m_col;
            m_locked = 1;
            m_run    = 0;
            m_hold   = 0;
            m_quiet  = 0;
         end
      end else begin
         m_run = 0;
         m_col = (m_col + 1) % 4;
      end
   endtask

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Runs one scan period; the tick edge is the last of SCAN_DIV rising edges since the previous one.
   task automatic run_tick(output bit strobed);
      int         stray;
      bit         exp_strobe;
      logic [3:0] rows;
      stray = 0;
      repeat (SCAN_DIV - 1) begin
         @(posedge IN_clk);
         #1;
         if (kif.OUT_key) stray++;
      end
      rows = rows_for(keys, m_col);
      @(posedge IN_clk);
      #1;
      model_tick(rows, exp_strobe);
      checkOutput("key_gap", stray, 0);
      checkOutput("key", kif.OUT_key, exp_strobe);
      checkOutput("col", kif.OUT_col, col_pattern(m_col));
      checkOutput("value", kif.OUT_value, m_value);
      checkOutput("held", kif.OUT_held, m_locked);
      strobed = kif.OUT_key;
   endtask

   task automatic applyStimulus(input logic [15:0] k, input int nticks, output int strobes);
      bit s;
      keys    = k;
      strobes = 0;
      for (int i = 0; i < nticks; i++) begin
         run_tick(s);
         if (s) strobes++;
      end
   endtask

   task automatic check_reset_values(input string tag);
      checkOutput({tag, "_col"}, kif.OUT_col, 4'b1110);
      checkOutput({tag, "_value"}, kif.OUT_value, 4'h0);
      checkOutput({tag, "_key"}, kif.OUT_key, 1'b0);
      checkOutput({tag, "_held"}, kif.OUT_held, 1'b0);
   endtask

   initial begin : main
      vec_t        tbl [6];
      int          strobes, acc, n, hold;
      bit          s, found;
      logic [31:0] mask, exp_mask;
      logic [15:0] k;

      tbl[0] = '{16'h0000, 4, 0, 4'b1110, 4'h0, 1'b0};
`ifdef KEYPAD_REPEAT_EN
      tbl[1] = '{16'h0200, 20, 4, 4'b1101, 4'h9, 1'b1};
`else
      tbl[1] = '{16'h0200, 20, 1, 4'b1101, 4'h9, 1'b1};
`endif
      tbl[2] = '{16'h0000, 2, 0, 4'b1101, 4'h9, 1'b1};
      tbl[3] = '{16'h0000, 1, 0, 4'b1011, 4'h9, 1'b0};
      tbl[4] = '{16'h1001, 5, 1, 4'b1110, 4'h0, 1'b1};
      tbl[5] = '{16'h0000, 3, 0, 4'b1101, 4'h0, 1'b0};

      model_reset();
      #2;
      check_reset_values("reset");
      repeat (2) @(negedge IN_clk);
      IN_reset = 1'b1;

      for (int i = 0; i < 6; i++) begin
         applyStimulus(tbl[i].keys, tbl[i].ticks, strobes);
         checkOutput($sformatf("tbl%0d_strobes", i), strobes, tbl[i].exp_strobes);
         checkOutput($sformatf("tbl%0d_col", i), kif.OUT_col, tbl[i].exp_col);
         checkOutput($sformatf("tbl%0d_value", i), kif.OUT_value, tbl[i].exp_value);
         checkOutput($sformatf("tbl%0d_held", i), kif.OUT_held, tbl[i].exp_held);
      end

      $display("[TB] bouncing row0 on column3");
      acc = 0;
      for (int i = 0; i < 10; i++) begin
         applyStimulus((i % 2 == 0) ? 16'h0008 : 16'h0000, 1, strobes);
         acc += strobes;
      end
      checkOutput("bounce_strobes", acc, 0);
      applyStimulus(16'h0008, 8, strobes);
      checkOutput("stable_strobes", strobes, 1);
      checkOutput("stable_value", kif.OUT_value, 4'h3);
      applyStimulus(16'h0000, 3, strobes);

      $display("[TB] reset during debounce");
      keys  = 16'h0040;
      found = 0;
      for (int i = 0; i < 12 && !found; i++) begin
         run_tick(s);
         if (m_run == 2) found = 1;
      end
      checkOutput("reach_debounce", found, 1'b1);
      #2;
      IN_reset = 1'b0;
      #1;
      check_reset_values("midreset");
      model_reset();
      repeat (2) @(negedge IN_clk);
      IN_reset = 1'b1;
      applyStimulus(16'h0040, 12, strobes);
      checkOutput("post_reset_strobes", strobes, 1);
      checkOutput("post_reset_value", kif.OUT_value, 4'h6);
      applyStimulus(16'h0000, 3, strobes);

      $display("[TB] long hold for auto-repeat");
      keys  = 16'h8000;
      found = 0;
      for (int i = 0; i < 12 && !found; i++) begin
         run_tick(s);
         if (s) found = 1;
      end
      checkOutput("repeat_accept", found, 1'b1);
      mask = '0;
      for (int t = 1; t <= 20; t++) begin
         run_tick(s);
         if (s) mask[t] = 1'b1;
      end
`ifdef KEYPAD_REPEAT_EN
      exp_mask = 32'h0011_1100;
`else
      exp_mask = 32'h0000_0000;
`endif
      checkOutput("repeat_mask", mask, exp_mask);
      checkOutput("repeat_value", kif.OUT_value, 4'hF);
      applyStimulus(16'h0000, 3, strobes);

      $display("[TB] random key activity");
      for (int seg = 0; seg < 40; seg++) begin
         k = '0;
         n = $urandom_range(0, 2);
         for (int j = 0; j < n; j++) k[$urandom_range(0, 15)] = 1'b1;
         hold = $urandom_range(1, 10);
         applyStimulus(k, hold, strobes);
      end
      applyStimulus(16'h0000, 4, strobes);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
